// File: rtl/seg7_scan_ctrl.sv
// Multiplexed seven-segment scan controller: double-buffered BCD load port,
// one-hot digit scan with per-digit dwell, inter-digit blank gap and leading-zero blanking.
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 10_000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ena,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  input  logic                    blank_lz,
  output logic [3:0]              digit_out,
  output logic                    digit_blank,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    scan_tick
);

  localparam int              IW         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [23:0]     DWELL_LAST = 24'(DWELL_CYCLES - 1);
  localparam logic [23:0]     GAP_LAST   = 24'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [IW-1:0]   IDX_LAST   = IW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t                  state_r, state_s;
  logic [IW-1:0]           idx_r, idx_s;
  logic [23:0]             cnt_r, cnt_s;
  logic [4*NUM_DIGITS-1:0] active_r, active_s;
  logic [4*NUM_DIGITS-1:0] shadow_r, shadow_s;
  logic                    pending_r, pending_s;
  logic                    advance_s, commit_s, tick_s;
  logic [NUM_DIGITS-1:0]   lz_s;
  logic [NUM_DIGITS-1:0]   sel_s;
  logic [3:0]              out_s;
  logic                    blank_s;

  // Scan sequencing, frame commit and load handshake for the next cycle.
  always_comb begin
    state_s   = state_r;
    idx_s     = idx_r;
    cnt_s     = cnt_r;
    active_s  = active_r;
    shadow_s  = shadow_r;
    pending_s = pending_r;
    advance_s = 1'b0;
    commit_s  = 1'b0;
    tick_s    = 1'b0;

    case (state_r)
      IDLE: begin
        commit_s = pending_r;
        if (ena) begin
          state_s = SHOW;
          idx_s   = '0;
          cnt_s   = 24'd0;
        end else begin
          idx_s   = '0;
          cnt_s   = 24'd0;
        end
      end
      SHOW: begin
        if (!ena) begin
          state_s = IDLE;
          idx_s   = '0;
          cnt_s   = 24'd0;
        end else if (cnt_r == DWELL_LAST) begin
          if (BLANK_CYCLES == 0) begin
            advance_s = 1'b1;
          end else begin
            state_s = GAP;
            cnt_s   = 24'd0;
          end
        end else begin
          cnt_s = cnt_r + 24'd1;
        end
      end
      GAP: begin
        if (!ena) begin
          state_s = IDLE;
          idx_s   = '0;
          cnt_s   = 24'd0;
        end else if (cnt_r == GAP_LAST) begin
          advance_s = 1'b1;
        end else begin
          cnt_s = cnt_r + 24'd1;
        end
      end
      default: begin
        state_s = IDLE;
        idx_s   = '0;
        cnt_s   = 24'd0;
      end
    endcase

    if (advance_s) begin
      state_s = SHOW;
      cnt_s   = 24'd0;
      tick_s  = 1'b1;
      if (idx_r == IDX_LAST) begin
        idx_s    = '0;
        commit_s = pending_r;
      end else begin
        idx_s    = idx_r + IW'(1);
      end
    end else begin
      tick_s = 1'b0;
    end

    // Commit and accept are exclusive: accept needs pending low, commit needs it high.
    if (commit_s) begin
      active_s  = shadow_r;
      pending_s = 1'b0;
    end else if (load_valid && !pending_r) begin
      shadow_s  = load_data;
      pending_s = 1'b1;
    end else begin
      pending_s = pending_r;
    end
  end

  // Leading-zero mask: digit i is blankable when it and every higher digit is zero.
  always_comb begin
    logic hi_zero;
    hi_zero = 1'b1;
    lz_s    = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      hi_zero = hi_zero & (active_s[4*i +: 4] == 4'd0);
      lz_s[i] = blank_lz & hi_zero & (i != 0);
    end
  end

  // Display values derived from the next state so outputs line up with it.
  always_comb begin
    sel_s   = '0;
    out_s   = 4'd0;
    blank_s = 1'b1;
    if (state_s == SHOW) begin
      sel_s = NUM_DIGITS'(1'b1) << idx_s;
      if (lz_s[idx_s]) begin
        out_s   = 4'd0;
        blank_s = 1'b1;
      end else begin
        out_s   = active_s[{idx_s, 2'b00} +: 4];
        blank_s = 1'b0;
      end
    end else begin
      sel_s   = '0;
      out_s   = 4'd0;
      blank_s = 1'b1;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      idx_r       <= '0;
      cnt_r       <= 24'd0;
      active_r    <= '0;
      shadow_r    <= '0;
      pending_r   <= 1'b0;
      digit_sel   <= '0;
      digit_out   <= 4'd0;
      digit_blank <= 1'b1;
      scan_tick   <= 1'b0;
      load_ready  <= 1'b1;
    end else begin
      state_r     <= state_s;
      idx_r       <= idx_s;
      cnt_r       <= cnt_s;
      active_r    <= active_s;
      shadow_r    <= shadow_s;
      pending_r   <= pending_s;
      digit_sel   <= sel_s;
      digit_out   <= out_s;
      digit_blank <= blank_s;
      scan_tick   <= tick_s;
      load_ready  <= !pending_s;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: a gapped instance (dwell 4, gap 2) and a gapless one (dwell 4, gap 0)
// checked every cycle against a frame-position model, plus a vector table and directed corner sequences.
module tb_seg7_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset, ena, load_valid, blank_lz;
  logic [15:0] load_data;
  logic        a_ready, a_blank, a_tick, b_ready, b_blank, b_tick;
  logic [3:0]  a_out, a_sel, b_out, b_sel;

  int total = 0;
  int bad   = 0;

  // model state per instance (0 = gapped, 1 = gapless)
  bit          m_run  [2];
  int          m_k    [2];
  logic [15:0] m_act  [2];
  logic [15:0] m_sh   [2];
  bit          m_pend [2];
  bit          m_lz   [2];

  typedef struct {
    logic [3:0] sel;
    logic [3:0] out;
    logic       blank;
    logic       tick;
    int         rep;
  } vec_t;
  vec_t vecs [12];

  seg7_scan_ctrl #(.NUM_DIGITS(4), .DWELL_CYCLES(4), .BLANK_CYCLES(2)) dut_a (
    .clk(clk), .reset(reset), .ena(ena), .load_valid(load_valid), .load_ready(a_ready),
    .load_data(load_data), .blank_lz(blank_lz), .digit_out(a_out), .digit_blank(a_blank),
    .digit_sel(a_sel), .scan_tick(a_tick));

  seg7_scan_ctrl #(.NUM_DIGITS(4), .DWELL_CYCLES(4), .BLANK_CYCLES(0)) dut_b (
    .clk(clk), .reset(reset), .ena(ena), .load_valid(load_valid), .load_ready(b_ready),
    .load_data(load_data), .blank_lz(blank_lz), .digit_out(b_out), .digit_blank(b_blank),
    .digit_sel(b_sel), .scan_tick(b_tick));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scan position is pure arithmetic on cycles since enable: period = dwell + gap.
  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_run[i] = 1'b0; m_k[i] = 0; m_act[i] = 16'h0; m_sh[i] = 16'h0;
        m_pend[i] = 1'b0; m_lz[i] = 1'b0;
      end else begin
        bit commit, acc;
        int per;
        per    = (i == 0) ? 6 : 4;
        commit = 1'b0;
        acc    = load_valid && !m_pend[i];
        if (!m_run[i]) begin
          commit = m_pend[i];
          if (ena) begin m_run[i] = 1'b1; m_k[i] = 0; end
        end else if (!ena) begin
          m_run[i] = 1'b0;
        end else begin
          m_k[i]++;
          if ((m_k[i] % (4 * per)) == 0 && m_pend[i]) commit = 1'b1;
        end
        if (commit) begin
          m_act[i] = m_sh[i]; m_pend[i] = 1'b0;
        end else if (acc) begin
          m_sh[i] = load_data; m_pend[i] = 1'b1;
        end
        m_lz[i] = blank_lz;
      end
    end
  endtask

  function automatic logic [10:0] model_exp(input int i);
    logic [3:0]  sel = 4'd0, out = 4'd0;
    logic        blank = 1'b1, tick = 1'b0;
    logic [15:0] hi;
    int          per, pos, dig;
    per = (i == 0) ? 6 : 4;
    if (m_run[i]) begin
      pos  = m_k[i] % per;
      dig  = (m_k[i] / per) % 4;
      tick = (m_k[i] > 0) && (pos == 0);
      if (pos < 4) begin
        sel = 4'b0001 << dig;
        hi  = m_act[i] >> (4 * dig);
        if (m_lz[i] && dig > 0 && hi == 16'h0) begin
          blank = 1'b1; out = 4'd0;
        end else begin
          blank = 1'b0; out = hi[3:0];
        end
      end
    end
    return {sel, out, blank, tick, !m_pend[i]};
  endfunction

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    chk("model_a", {a_sel, a_out, a_blank, a_tick, a_ready}, model_exp(0));
    chk("model_b", {b_sel, b_out, b_blank, b_tick, b_ready}, model_exp(1));
  endtask

  task automatic wait_sel(input logic [3:0] target, input int budget);
    int n = 0;
    while (a_sel !== target && n < budget) begin cyc(); n++; end
    chk("wait_sel", a_sel, target);
  endtask

  initial begin
    vecs[0]  = '{4'b0001, 4'd4, 1'b0, 1'b0, 4};
    vecs[1]  = '{4'b0000, 4'd0, 1'b1, 1'b0, 2};
    vecs[2]  = '{4'b0010, 4'd3, 1'b0, 1'b1, 1};
    vecs[3]  = '{4'b0010, 4'd3, 1'b0, 1'b0, 3};
    vecs[4]  = '{4'b0000, 4'd0, 1'b1, 1'b0, 2};
    vecs[5]  = '{4'b0100, 4'd2, 1'b0, 1'b1, 1};
    vecs[6]  = '{4'b0100, 4'd2, 1'b0, 1'b0, 3};
    vecs[7]  = '{4'b0000, 4'd0, 1'b1, 1'b0, 2};
    vecs[8]  = '{4'b1000, 4'd1, 1'b0, 1'b1, 1};
    vecs[9]  = '{4'b1000, 4'd1, 1'b0, 1'b0, 3};
    vecs[10] = '{4'b0000, 4'd0, 1'b1, 1'b0, 2};
    vecs[11] = '{4'b0001, 4'd4, 1'b0, 1'b1, 1};

    reset = 1'b1; ena = 1'b0; load_valid = 1'b0; load_data = 16'h0; blank_lz = 1'b0;
    cyc(); cyc();
    chk("reset_a", {a_sel, a_out, a_blank, a_tick, a_ready}, {4'd0, 4'd0, 1'b1, 1'b0, 1'b1});
    reset = 1'b0;
    cyc();

    // load while idle: ready low for exactly one cycle
    load_valid = 1'b1; load_data = 16'h1234;
    cyc();
    chk("ready_low", a_ready, 1'b0);
    load_valid = 1'b0;
    cyc();
    chk("ready_back", a_ready, 1'b1);

    // full frame plus wrap; gapless instance never shows an all-off cycle
    ena = 1'b1;
    foreach (vecs[v]) begin
      for (int r = 0; r < vecs[v].rep; r++) begin
        cyc();
        chk("table", {a_sel, a_out, a_blank, a_tick},
            {vecs[v].sel, vecs[v].out, vecs[v].blank, vecs[v].tick});
        chk("b_no_gap", {31'd0, b_sel != 4'd0}, 32'd1);
      end
    end

    // mid-frame load is held back until the frame ends; load while pending is dropped
    wait_sel(4'b0010, 40);
    load_valid = 1'b1; load_data = 16'h5678;
    cyc();
    load_data = 16'h9999;
    cyc(); cyc();
    load_valid = 1'b0;
    chk("ready_pending", a_ready, 1'b0);
    wait_sel(4'b0100, 40); chk("old_d2", a_out, 4'd2);
    wait_sel(4'b1000, 40); chk("old_d3", a_out, 4'd1);
    wait_sel(4'b0001, 40); chk("new_d0", a_out, 4'd8);
    wait_sel(4'b0010, 40); chk("new_d1", a_out, 4'd7);
    chk("ready_commit", a_ready, 1'b1);

    // leading-zero blanking
    ena = 1'b0; blank_lz = 1'b1;
    cyc();
    load_valid = 1'b1; load_data = 16'h0040;
    cyc();
    load_valid = 1'b0;
    cyc();
    ena = 1'b1;
    wait_sel(4'b0001, 40); chk("lz_d0", {a_out, a_blank}, {4'd0, 1'b0});
    wait_sel(4'b0010, 40); chk("lz_d1", {a_out, a_blank}, {4'd4, 1'b0});
    wait_sel(4'b0100, 40); chk("lz_d2", {a_out, a_blank}, {4'd0, 1'b1});
    wait_sel(4'b1000, 40); chk("lz_d3", {a_out, a_blank}, {4'd0, 1'b1});
    ena = 1'b0;
    cyc();
    load_valid = 1'b1; load_data = 16'h0000;
    cyc();
    load_valid = 1'b0;
    cyc();
    ena = 1'b1;
    wait_sel(4'b0001, 40); chk("lz0_d0", {a_out, a_blank}, {4'd0, 1'b0});
    wait_sel(4'b0010, 40); chk("lz0_d1", {a_out, a_blank}, {4'd0, 1'b1});
    blank_lz = 1'b0;

    // enable drop in the second cycle of digit 2, then restart with a full dwell
    wait_sel(4'b0100, 40);
    cyc();
    ena = 1'b0;
    cyc();
    chk("drop_blank", {a_sel, a_blank}, {4'd0, 1'b1});
    cyc();
    ena = 1'b1;
    for (int r = 0; r < 4; r++) begin
      cyc();
      chk("restart_d0", a_sel, 4'b0001);
    end
    cyc();
    chk("restart_gap", a_sel, 4'b0000);

    // reset during a gap with a frame pending
    wait_sel(4'b0001, 40);
    load_valid = 1'b1; load_data = 16'hABCD;
    cyc();
    load_valid = 1'b0;
    chk("pend_before_rst", a_ready, 1'b0);
    wait_sel(4'b0000, 20);
    reset = 1'b1;
    cyc();
    chk("reset_gap", {a_sel, a_out, a_blank, a_tick, a_ready}, {4'd0, 4'd0, 1'b1, 1'b0, 1'b1});
    reset = 1'b0;
    cyc();
    chk("after_rst", {a_sel, a_out, a_blank}, {4'b0001, 4'd0, 1'b0});

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      ena        = ($urandom_range(0, 39) != 0);
      load_valid = ($urandom_range(0, 3) == 0);
      load_data  = 16'($urandom);
      if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
      reset      = ($urandom_range(0, 299) == 0);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
